// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: one data-cache transaction per EX/MEM load/store, held until dhit.
// Optional abort-on-timeout is enabled by defining MEMSTAGE_TIMEOUT_EN.
module mem_access_ctrl #(
    parameter int WORD_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic              flush,
    input  logic              req_ren,
    input  logic              req_wen,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic [WORD_W-1:0] load,
    output logic              mem_stall,
    output logic              acc_done,
    output logic              timeout
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state, state_next;
    logic              start;
    logic              is_wr;
    logic              squash_q;
    logic              squashed;
    logic              expire;
    logic [WORD_W-1:0] addr_q, wdata_q, load_q, load_next;

    assign start    = (req_ren | req_wen) & ~flush;
    assign squashed = squash_q | flush;

`ifdef MEMSTAGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt;
    logic             timeout_q;

    // Expire on the last permitted ACCESS cycle so the request is up for exactly TIMEOUT_CYC cycles.
    assign expire  = (state == ACCESS) && !dhit && (cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign timeout = timeout_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state != ACCESS) cnt <= '0;
            else                 cnt <= cnt + 1'b1;
            if (expire) timeout_q <= 1'b1;
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_next = state;
        load_next  = load_q;
        case (state)
            IDLE: begin
                if (start) state_next = ACCESS;
            end
            ACCESS: begin
                // A squashed access still completes on the cache side but never reaches MEM/WB.
                if (dhit) begin
                    state_next = squashed ? IDLE : DONE;
                    if (!is_wr && !squashed) load_next = dmemload;
                end else if (expire) begin
                    state_next = squashed ? IDLE : DONE;
                    if (!is_wr && !squashed) load_next = WORD_W'(32'hDEADBEEF);
                end
            end
            DONE: begin
                if (ihit || flush) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            is_wr    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            load_q   <= '0;
            squash_q <= 1'b0;
        end else begin
            state  <= state_next;
            load_q <= load_next;
            if (state == IDLE && start) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                is_wr   <= req_wen;
            end
            if (state_next == IDLE)
                squash_q <= 1'b0;
            else if (state == ACCESS && flush)
                squash_q <= 1'b1;
        end
    end

    assign dmemREN   = (state == ACCESS) && !is_wr;
    assign dmemWEN   = (state == ACCESS) && is_wr;
    assign dmemaddr  = addr_q;
    assign dmemstore = wdata_q;
    assign load      = load_q;
    assign mem_stall = ((state == IDLE) && start) || (state == ACCESS);
    assign acc_done  = (state == DONE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl; the timeout scenario runs only when MEMSTAGE_TIMEOUT_EN is defined.
module tb_mem_access_ctrl;

    localparam int WORD_W = 32;
`ifdef MEMSTAGE_TIMEOUT_EN
    localparam int TCYC = 4;
`else
    localparam int TCYC = 255;
`endif

    logic              CLK, RST, ihit, flush, req_ren, req_wen, dhit;
    logic [WORD_W-1:0] req_addr, req_wdata, dmemload;
    logic              dmemREN, dmemWEN, mem_stall, acc_done, timeout;
    logic [WORD_W-1:0] dmemaddr, dmemstore, load;

    mem_access_ctrl #(.WORD_W(WORD_W), .TIMEOUT_CYC(TCYC)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .flush(flush),
        .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
        .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .load(load), .mem_stall(mem_stall), .acc_done(acc_done), .timeout(timeout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          len;
    } txn_t;

    txn_t        txq[$];
    logic [31:0] doneq[$];
    txn_t        cur;
    logic        have_cur = 1'b0;
    logic        prev_act = 1'b0;
    logic        prev_done = 1'b0;
    logic        act;
    int          burst_len = 0;
    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] exp_load;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: each new cache request and each acc_done rise is matched against the scoreboard.
    always @(negedge CLK) begin
        act = dmemREN | dmemWEN;
        if (act && !prev_act) begin
            burst_len = 1;
            if (txq.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_request: got addr 0x%08h, expected no request", dmemaddr);
            end else begin
                cur      = txq.pop_front();
                have_cur = 1'b1;
                checkOutput("req_kind_wen", dmemWEN, cur.wr);
                checkOutput("req_kind_ren", dmemREN, !cur.wr);
                checkOutput("req_addr", dmemaddr, cur.addr);
                if (cur.wr) checkOutput("req_wdata", dmemstore, cur.wdata);
            end
        end else if (act) begin
            burst_len++;
            if (have_cur) begin
                checkOutput("addr_stable", dmemaddr, cur.addr);
                if (cur.wr) checkOutput("wdata_stable", dmemstore, cur.wdata);
            end
        end
        if (!act && prev_act && have_cur) begin
            checkOutput("burst_len", burst_len, cur.len);
            have_cur = 1'b0;
        end
        if (acc_done && !prev_done) begin
            if (doneq.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_acc_done: got load 0x%08h, expected no completion", load);
            end else begin
                checkOutput("load_on_done", load, doneq.pop_front());
            end
        end
        prev_act  = act;
        prev_done = acc_done;
    end

    task automatic applyStimulus(input logic ren, input logic wen, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int dhit_cyc,
                                 input logic [31:0] rdata, input int hold);
        txn_t t;
        t.wr = wen; t.addr = addr; t.wdata = wdata; t.len = dhit_cyc;
        txq.push_back(t);
        if (!wen) exp_load = rdata;
        doneq.push_back(exp_load);
        req_ren = ren; req_wen = wen; req_addr = addr; req_wdata = wdata;
        @(negedge CLK);
        checkOutput("stall_req_cycle", mem_stall, 1'b1);
        tick();
        // Upstream operands change mid-access; the latched copies must not follow.
        req_addr  = addr ^ 32'h0000_FFFF;
        req_wdata = ~wdata;
        for (int i = 1; i < dhit_cyc; i++) tick();
        dhit = 1'b1; dmemload = rdata;
        tick();
        dhit = 1'b0; dmemload = 32'h0;
        @(negedge CLK);
        checkOutput("done_acc_done", acc_done, 1'b1);
        checkOutput("done_stall", mem_stall, 1'b0);
        repeat (hold) tick();
        ihit = 1'b1;
        tick();
        ihit = 1'b0; req_ren = 1'b0; req_wen = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST = 1'b1; ihit = 1'b0; flush = 1'b0; req_ren = 1'b0; req_wen = 1'b0; dhit = 1'b0;
        req_addr = '0; req_wdata = '0; dmemload = '0; exp_load = 32'h0;
        repeat (2) tick();
        @(negedge CLK);
        checkOutput("rst_ren", dmemREN, 1'b0);
        checkOutput("rst_wen", dmemWEN, 1'b0);
        checkOutput("rst_addr", dmemaddr, 32'h0);
        checkOutput("rst_load", load, 32'h0);
        checkOutput("rst_stall", mem_stall, 1'b0);
        checkOutput("rst_done", acc_done, 1'b0);
        checkOutput("rst_timeout", timeout, 1'b0);
        RST = 1'b0;
        tick();

        $display("[TB] load 0x100, dhit in 3rd access cycle");
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 3, 32'hCAFEF00D, 1);

        $display("[TB] store 0x200, held 4 cycles in DONE");
        applyStimulus(1'b0, 1'b1, 32'h200, 32'h12345678, 2, 32'h0, 4);

        $display("[TB] stray dhit while idle");
        dhit = 1'b1; dmemload = 32'h55555555;
        tick();
        dhit = 1'b0; dmemload = 32'h0;
        @(negedge CLK);
        checkOutput("stray_dhit_load", load, exp_load);
        checkOutput("stray_dhit_done", acc_done, 1'b0);

        $display("[TB] flush in idle blocks start");
        req_ren = 1'b1; req_addr = 32'h280; flush = 1'b1;
        @(negedge CLK);
        checkOutput("flush_idle_stall", mem_stall, 1'b0);
        tick();
        @(negedge CLK);
        checkOutput("flush_idle_ren", dmemREN, 1'b0);
        flush = 1'b0; req_ren = 1'b0;
        tick();

        $display("[TB] load flushed in 2nd access cycle");
        txq.push_back('{wr: 1'b0, addr: 32'h300, wdata: 32'h0, len: 4});
        req_ren = 1'b1; req_addr = 32'h300;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0; req_ren = 1'b0;
        tick();
        dhit = 1'b1; dmemload = 32'hBAD0BAD0;
        tick();
        dhit = 1'b0; dmemload = 32'h0;
        @(negedge CLK);
        checkOutput("flush_acc_done", acc_done, 1'b0);
        checkOutput("flush_stall", mem_stall, 1'b0);
        checkOutput("flush_load_kept", load, exp_load);
        tick();

        $display("[TB] back-to-back loads");
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1, 32'h11111111, 0);
        applyStimulus(1'b1, 1'b0, 32'h14, 32'h0, 2, 32'h22222222, 0);

        $display("[TB] read and write together, write wins");
        applyStimulus(1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, 2, 32'h0, 0);

        $display("[TB] reset mid-access");
        txq.push_back('{wr: 1'b0, addr: 32'h400, wdata: 32'h0, len: 2});
        req_ren = 1'b1; req_addr = 32'h400;
        tick();
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0; req_ren = 1'b0; exp_load = 32'h0;
        @(negedge CLK);
        checkOutput("midrst_ren", dmemREN, 1'b0);
        checkOutput("midrst_wen", dmemWEN, 1'b0);
        checkOutput("midrst_addr", dmemaddr, 32'h0);
        checkOutput("midrst_store", dmemstore, 32'h0);
        checkOutput("midrst_load", load, 32'h0);
        checkOutput("midrst_stall", mem_stall, 1'b0);
        checkOutput("midrst_done", acc_done, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h500, 32'h0, 2, 32'h0BADCAFE, 0);

`ifdef MEMSTAGE_TIMEOUT_EN
        $display("[TB] timeout on load without dhit");
        txq.push_back('{wr: 1'b0, addr: 32'h600, wdata: 32'h0, len: TCYC});
        exp_load = 32'hDEADBEEF;
        doneq.push_back(exp_load);
        req_ren = 1'b1; req_addr = 32'h600;
        tick();
        for (int n = 0; n < 50 && !acc_done; n++) tick();
        checkOutput("timeout_reached_done", acc_done, 1'b1);
        @(negedge CLK);
        checkOutput("timeout_flag", timeout, 1'b1);
        ihit = 1'b1;
        tick();
        ihit = 1'b0; req_ren = 1'b0;
        tick();
        @(negedge CLK);
        checkOutput("timeout_sticky", timeout, 1'b1);
        RST = 1'b1;
        tick();
        RST = 1'b0; exp_load = 32'h0;
        @(negedge CLK);
        checkOutput("timeout_cleared", timeout, 1'b0);
`else
        @(negedge CLK);
        checkOutput("timeout_tied_low", timeout, 1'b0);
`endif

        repeat (3) tick();
        checkOutput("txq_drained", txq.size(), 0);
        checkOutput("doneq_drained", doneq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
